// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : button_conditioner
//  Description : Multi-channel push-button conditioner. Each channel
//                synchronises a raw asynchronous button, debounces it into a
//                clean level and produces single-cycle press, release,
//                auto-repeat and strobe (press | repeat) events.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] BTN,
  output logic [WIDTH-1:0] Level,
  output logic [WIDTH-1:0] Press,
  output logic [WIDTH-1:0] Release,
  output logic [WIDTH-1:0] Repeat,
  output logic [WIDTH-1:0] Strobe
);

  // Debounce counter only has to reach D-1, so ceil(log2(D)) bits suffice.
  localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);
  localparam bit               REP_ON      = (REPEAT_EN != 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_RPT   = 2'd2
  } rep_state_t;

  genvar ch;
  generate
    for (ch = 0; ch < WIDTH; ch++) begin : g_chan
      logic             s1;
      logic             s2;
      logic             level_q;
      logic             press_q;
      logic             release_q;
      logic             repeat_q;
      logic             strobe_q;
      logic [DB_W-1:0]  db_cnt;
      logic [DB_W-1:0]  db_cnt_nxt;
      logic             level_nxt;
      logic             press_nxt;
      logic             release_nxt;
      logic             repeat_nxt;
      logic [REP_W-1:0] rep_cnt;
      logic [REP_W-1:0] rep_cnt_nxt;
      rep_state_t       state;
      rep_state_t       state_nxt;

      // Debounce: any sample agreeing with the current level restarts qualification.
      always_comb begin
        level_nxt   = level_q;
        db_cnt_nxt  = '0;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        if (s2 != level_q) begin
          if (db_cnt == DB_LAST) begin
            level_nxt   = s2;
            press_nxt   = s2;
            release_nxt = ~s2;
          end else begin
            db_cnt_nxt = db_cnt + 1'b1;
          end
        end
      end

      // Repeat FSM next state: a release always wins over a terminal count.
      always_comb begin
        state_nxt   = state;
        rep_cnt_nxt = '0;
        repeat_nxt  = 1'b0;
        case (state)
          ST_IDLE: begin
            if (press_nxt && REP_ON) begin
              state_nxt = ST_DELAY;
            end
          end
          ST_DELAY: begin
            if (release_nxt) begin
              state_nxt = ST_IDLE;
            end else if (rep_cnt == DELAY_LAST) begin
              repeat_nxt = 1'b1;
              state_nxt  = ST_RPT;
            end else begin
              rep_cnt_nxt = rep_cnt + 1'b1;
            end
          end
          ST_RPT: begin
            if (release_nxt) begin
              state_nxt = ST_IDLE;
            end else if (rep_cnt == PERIOD_LAST) begin
              repeat_nxt = 1'b1;
            end else begin
              rep_cnt_nxt = rep_cnt + 1'b1;
            end
          end
          default: begin
            state_nxt = ST_IDLE;
          end
        endcase
      end

      // Synchroniser, debounced level and registered event pulses.
      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
          s1        <= 1'b0;
          s2        <= 1'b0;
          level_q   <= 1'b0;
          db_cnt    <= '0;
          press_q   <= 1'b0;
          release_q <= 1'b0;
          repeat_q  <= 1'b0;
          strobe_q  <= 1'b0;
        end else begin
          s1        <= BTN[ch];
          s2        <= s1;
          level_q   <= level_nxt;
          db_cnt    <= db_cnt_nxt;
          press_q   <= press_nxt;
          release_q <= release_nxt;
          repeat_q  <= repeat_nxt;
          strobe_q  <= press_nxt | repeat_nxt;
        end
      end

      // Repeat FSM state and repeat counter.
      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
          state   <= ST_IDLE;
          rep_cnt <= '0;
        end else begin
          state   <= state_nxt;
          rep_cnt <= rep_cnt_nxt;
        end
      end

      assign Level[ch]   = level_q;
      assign Press[ch]   = press_q;
      assign Release[ch] = release_q;
      assign Repeat[ch]  = repeat_q;
      assign Strobe[ch]  = strobe_q;
    end
  endgenerate

endmodule
`default_nettype wire
